// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the four-digit seven-segment scan driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [3:0] AN_OFF = 4'hF;

  typedef logic [1:0] digit_idx_t;

  // Active-low one-hot anode select for a digit index.
  function automatic logic [3:0] an_select(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display bus: packed BCD digits and decimal points in, multiplexed pins out.
// The master side owns the digit data; the slave side is the scan driver.
interface seven_seg_scan_if;
  logic [15:0] DataIn;
  logic [3:0]  DpIn;
  logic [6:0]  Seg;
  logic        Dp;
  logic [3:0]  An;
  logic        FrameDone;

  modport master (
    output DataIn, DpIn,
    input  Seg, Dp, An, FrameDone
  );

  modport slave (
    input  DataIn, DpIn,
    output Seg, Dp, An, FrameDone
  );
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational nibble to active-low seven-segment decoder.
// Non-BCD nibbles (A..F) render as a centre dash so bad data is visible.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // NOTE: every path through a combinational block must assign the output;
  // the default arm here is what keeps this from inferring a latch.
  always_comb begin
    unique case (i_nibble)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed Basys3 seven-segment driver: one digit per refresh slot,
// input snapshotted once per frame, leading-zero blanking, registered pins.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic            Clk,
  input  logic            ResetN,
  seven_seg_scan_if.slave bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_pre_cnt;
  digit_idx_t       r_idx;
  logic             r_started;
  logic [15:0]      r_frame;
  logic [3:0]       r_frame_dp;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic             r_frame_done;

  logic             w_tick;
  logic [3:0]       w_nibble;
  logic [6:0]       w_dec_seg;
  logic             w_blank;

  assign w_tick   = (r_pre_cnt == CNT_LAST);
  assign w_nibble = r_frame[{r_idx, 2'b00} +: 4];

  bcd_to_seg u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_dec_seg)
  );

  // A digit is a leading zero only if it and every more-significant digit
  // are zero; non-BCD nibbles compare non-zero and so stop the blanking.
  always_comb begin
    w_blank = 1'b0;
    if (BLANK_LEADING) begin
      unique case (r_idx)
        2'd3:    w_blank = (r_frame[15:12] == 4'd0);
        2'd2:    w_blank = (r_frame[15:8]  == 8'd0);
        2'd1:    w_blank = (r_frame[15:4]  == 12'd0);
        default: w_blank = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register below samples the pre-edge values regardless of statement order.
  // NOTE: the snapshot registers are plain flops, not a RAM, so they take the
  // async reset like everything else and the first frame starts from zero.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_pre_cnt    <= '0;
      r_idx        <= '0;
      r_started    <= 1'b0;
      r_frame      <= '0;
      r_frame_dp   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_pre_cnt    <= w_tick ? '0 : r_pre_cnt + CNT_W'(1);
      r_frame_done <= 1'b0;
      if (w_tick) begin
        if (!r_started) begin
          r_started  <= 1'b1;
          r_idx      <= '0;
          r_frame    <= bus.DataIn;
          r_frame_dp <= bus.DpIn;
        end else if (r_idx == 2'd3) begin
          r_idx        <= '0;
          r_frame      <= bus.DataIn;
          r_frame_dp   <= bus.DpIn;
          r_frame_done <= 1'b1;
        end else begin
          r_idx <= digit_idx_t'(r_idx + 2'd1);
        end
      end
    end
  end

  // Pin registers follow the current slot one cycle later and stay dark
  // until the first snapshot has been taken.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else if (!r_started || w_blank) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= an_select(r_idx);
      r_seg <= w_dec_seg;
      r_dp  <= ~r_frame_dp[r_idx];
    end
  end

  assign bus.An        = r_an;
  assign bus.Seg       = r_seg;
  assign bus.Dp        = r_dp;
  assign bus.FrameDone = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan at REFRESH_DIV=4, with one blanking
// and one non-blanking instance fed the same digits.
module tb_seven_seg_scan;

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100,
                         P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010,
                         P6 = 7'b0000010, P7 = 7'b1111000, P8 = 7'b0000000,
                         P9 = 7'b0010000, PD = 7'b0111111;

  typedef struct packed {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic [3:0]      lit;   // digits lit when leading zeros are blanked
    logic [3:0][6:0] seg;   // seg[i] = pattern of digit i when lit
  } frame_t;

  typedef struct {
    int          digit;
    logic [11:0] e_blank;   // {An, Seg, Dp} for BLANK_LEADING=1
    logic [11:0] e_full;    // {An, Seg, Dp} for BLANK_LEADING=0
  } exp_t;

  logic Clk;
  logic ResetN;
  bit   stop;
  int   vectors;
  int   fails;

  frame_t tbl [9];
  exp_t   q [$];

  seven_seg_scan_if bus ();
  seven_seg_scan_if bus_nb ();

  assign bus_nb.DataIn = bus.DataIn;
  assign bus_nb.DpIn   = bus.DpIn;

  seven_seg_scan #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus)
  );

  seven_seg_scan #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_dut_nb (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus_nb)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got An=%b Seg=%b Dp=%b FrameDone=%b, want An=%b Seg=%b Dp=%b FrameDone=%b",
               name, act[12:9], act[8:2], act[1], act[0], exp[12:9], exp[8:2], exp[1], exp[0]);
    end
  endtask

  task automatic push_frame(input int f);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.digit  = i;
      e.e_full = {~(4'b0001 << i), tbl[f].seg[i], ~tbl[f].dp[i]};
      e.e_blank = tbl[f].lit[i] ? e.e_full : {4'hF, 7'h7F, 1'b1};
      q.push_back(e);
    end
  endtask

  // Monitor: cycle n after reset release; digit slots start at n=5, 4 cycles each.
  initial begin : monitor
    int   cnt;
    int   p;
    bit   have;
    bit   fd;
    exp_t cur;
    cnt  = 0;
    have = 1'b0;
    forever begin
      @(posedge Clk);
      if (!ResetN) cnt = 0;
      else         cnt++;
      @(negedge Clk);
      if (stop) break;
      if (!ResetN || cnt <= 4) begin
        check($sformatf("off_blank n=%0d", cnt),
              {bus.An, bus.Seg, bus.Dp, bus.FrameDone}, {4'hF, 7'h7F, 1'b1, 1'b0});
        check($sformatf("off_full n=%0d", cnt),
              {bus_nb.An, bus_nb.Seg, bus_nb.Dp, bus_nb.FrameDone}, {4'hF, 7'h7F, 1'b1, 1'b0});
      end else begin
        p = (cnt - 5) % 4;
        if (p == 0) begin
          if (q.size() == 0) begin
            vectors++;
            fails++;
            have = 1'b0;
            $display("FAIL underflow n=%0d: slot started with no expectation queued", cnt);
          end else begin
            cur  = q.pop_front();
            have = 1'b1;
          end
        end
        if (have) begin
          fd = (cur.digit == 3) && (p == 3);
          check($sformatf("blank n=%0d dig=%0d", cnt, cur.digit),
                {bus.An, bus.Seg, bus.Dp, bus.FrameDone}, {cur.e_blank, fd});
          check($sformatf("full n=%0d dig=%0d", cnt, cur.digit),
                {bus_nb.An, bus_nb.Seg, bus_nb.Dp, bus_nb.FrameDone}, {cur.e_full, fd});
        end
      end
    end
  end

  initial begin : stimulus
    int now;

    //             data      dp     lit    seg {d3, d2, d1, d0}
    tbl[0] = '{16'h1234, 4'b0000, 4'b1111, {P1, P2, P3, P4}};
    tbl[1] = '{16'h5678, 4'b0000, 4'b1111, {P5, P6, P7, P8}};
    tbl[2] = '{16'h0050, 4'b0000, 4'b0011, {P0, P0, P5, P0}};
    tbl[3] = '{16'h0000, 4'b1111, 4'b0001, {P0, P0, P0, P0}};
    tbl[4] = '{16'hA00F, 4'b0100, 4'b1111, {PD, P0, P0, PD}};
    tbl[5] = '{16'h0009, 4'b0001, 4'b0001, {P0, P0, P0, P9}};
    tbl[6] = '{16'h0907, 4'b0000, 4'b0111, {P0, P9, P0, P7}};
    tbl[7] = '{16'h4321, 4'b1000, 4'b1111, {P4, P3, P2, P1}};
    tbl[8] = '{16'h0B00, 4'b0010, 4'b0111, {P0, PD, P0, P0}};

    vectors    = 0;
    fails      = 0;
    stop       = 1'b0;
    ResetN     = 1'b1;
    bus.DataIn = '0;
    bus.DpIn   = '0;
    #2;
    ResetN     = 1'b0;
    bus.DataIn = tbl[0].data;
    bus.DpIn   = tbl[0].dp;
    push_frame(0);
    repeat (3) @(posedge Clk);
    #1 ResetN = 1'b1;
    now = 0;

    // Each new frame's data lands mid digit-1 slot of the frame on display.
    for (int f = 1; f <= 6; f++) begin
      repeat (16 * f - 6 - now) @(posedge Clk);
      now = 16 * f - 6;
      #1;
      bus.DataIn = tbl[f].data;
      bus.DpIn   = tbl[f].dp;
      push_frame(f);
    end

    // Abort frame 6 in its digit-2 slot; the unseen slots are dropped.
    repeat (16 * 6 + 14 - now) @(posedge Clk);
    #1;
    ResetN = 1'b0;
    q.delete();
    bus.DataIn = tbl[7].data;
    bus.DpIn   = tbl[7].dp;
    push_frame(7);
    repeat (3) @(posedge Clk);
    #1 ResetN = 1'b1;
    now = 0;

    repeat (10 - now) @(posedge Clk);
    now = 10;
    #1;
    bus.DataIn = tbl[8].data;
    bus.DpIn   = tbl[8].dp;
    push_frame(8);

    repeat (16 + 21 - now) @(posedge Clk);
    #1;
    stop = 1'b1;

    vectors++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
